// File: rtl/noc_credit_sender.sv
// Credit-based transmit end of a flit link.
// Upstream flits are accepted while downstream buffer credits remain, and each
// accepted flit goes out registered one cycle later. A multi-flit packet keeps
// the destination of its head flit, and two sticky flags record protocol errors.
module noc_credit_sender #(
    parameter int FLIT_WIDTH   = 128,
    parameter int DEST_WIDTH   = 8,
    parameter int BUFFER_DEPTH = 8,
    parameter int CREDIT_WIDTH = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [FLIT_WIDTH-1:0]   data_in,
    input  logic [DEST_WIDTH-1:0]   dest_in,
    input  logic                    is_tail_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    err_credit_overflow,
    output logic                    err_dest_change
);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    localparam logic [CREDIT_WIDTH-1:0] FULL_CREDITS = CREDIT_WIDTH'(BUFFER_DEPTH);

    state_t                  state_reg, state_next;
    logic [CREDIT_WIDTH-1:0] credit_reg, credit_next;
    logic [DEST_WIDTH-1:0]   dest_lock_reg;
    logic [DEST_WIDTH-1:0]   dest_eff;
    logic                    lock_load;
    logic                    dest_mismatch;
    logic                    fire;
    logic                    overflow;

    // Ready depends only on the credit register, so there is no combinational
    // path from credit_in or valid_in to ready_out.
    assign ready_out    = (credit_reg != '0);
    assign credit_count = credit_reg;
    assign fire         = valid_in & ready_out;
    // A returned credit is only excess if no flit consumes one in the same cycle.
    assign overflow     = credit_in & (credit_reg == FULL_CREDITS) & ~fire;

    // Credit bookkeeping: a fire consumes one credit and an accepted return adds one.
    always_comb begin
        credit_next = credit_reg;
        if (fire && !credit_in) begin
            credit_next = credit_reg - CREDIT_WIDTH'(1);
        end else if (!fire && credit_in && !overflow) begin
            credit_next = credit_reg + CREDIT_WIDTH'(1);
        end
    end

    // Packet framing: choose the effective destination and track head/body position.
    always_comb begin
        state_next    = state_reg;
        dest_eff      = dest_in;
        lock_load     = 1'b0;
        dest_mismatch = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fire && !is_tail_in) begin
                    lock_load  = 1'b1;
                    state_next = IN_PKT;
                end
            end
            IN_PKT: begin
                dest_eff = dest_lock_reg;
                if (fire) begin
                    dest_mismatch = (dest_in != dest_lock_reg);
                    if (is_tail_in) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, credit counter and locked destination registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            credit_reg    <= FULL_CREDITS;
            dest_lock_reg <= '0;
        end else begin
            state_reg  <= state_next;
            credit_reg <= credit_next;
            if (lock_load) begin
                dest_lock_reg <= dest_in;
            end
        end
    end

    // Registered link outputs. The payload holds its last value while no flit is sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_out    <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
            is_tail_out <= 1'b0;
        end else begin
            send_out <= fire;
            if (fire) begin
                data_out    <= data_in;
                dest_out    <= dest_eff;
                is_tail_out <= is_tail_in;
            end
        end
    end

    // Sticky error flags. Only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_credit_overflow <= 1'b0;
            err_dest_change     <= 1'b0;
        end else begin
            if (overflow) begin
                err_credit_overflow <= 1'b1;
            end
            if (dest_mismatch) begin
                err_dest_change <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_credit_sender.sv
// Testbench for noc_credit_sender (BUFFER_DEPTH=4, FLIT_WIDTH=32, DEST_WIDTH=8).
// It runs directed scenarios and then randomized traffic. A transaction-level
// reference model checks every cycle.
module tb_noc_credit_sender;

    localparam int FW    = 32;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] data_in = '0;
    logic [DW-1:0] dest_in = '0;
    logic          is_tail_in = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out;
    logic          send_out;
    logic          credit_in = 1'b0;
    logic [CW-1:0] credit_count;
    logic          err_credit_overflow;
    logic          err_dest_change;

    noc_credit_sender #(
        .FLIT_WIDTH   (FW),
        .DEST_WIDTH   (DW),
        .BUFFER_DEPTH (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .data_in             (data_in),
        .dest_in             (dest_in),
        .is_tail_in          (is_tail_in),
        .valid_in            (valid_in),
        .ready_out           (ready_out),
        .data_out            (data_out),
        .dest_out            (dest_out),
        .is_tail_out         (is_tail_out),
        .send_out            (send_out),
        .credit_in           (credit_in),
        .credit_count        (credit_count),
        .err_credit_overflow (err_credit_overflow),
        .err_dest_change     (err_dest_change)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Transaction-level reference state.
    int            m_outstanding;   // flits sent minus credits accepted back
    bit            m_in_pkt;
    logic [DW-1:0] m_lock;
    logic          m_send;
    logic [FW-1:0] m_data;
    logic [DW-1:0] m_dest;
    logic          m_tail;
    logic          m_err_ovf;
    logic          m_err_dest;
    int            obs_sends;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_outstanding = 0;
        m_in_pkt      = 0;
        m_lock        = '0;
        m_send        = 0;
        m_data        = '0;
        m_dest        = '0;
        m_tail        = 0;
        m_err_ovf     = 0;
        m_err_dest    = 0;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".send"},   64'(send_out),            64'(m_send));
        check({where, ".data"},   64'(data_out),            64'(m_data));
        check({where, ".dest"},   64'(dest_out),            64'(m_dest));
        check({where, ".tail"},   64'(is_tail_out),         64'(m_tail));
        check({where, ".count"},  64'(credit_count),        64'(DEPTH - m_outstanding));
        check({where, ".eovf"},   64'(err_credit_overflow), 64'(m_err_ovf));
        check({where, ".edest"},  64'(err_dest_change),     64'(m_err_dest));
    endtask

    // One clock cycle: drive inputs at the falling edge, then check after the rising edge.
    task automatic step(input string where, input logic v, input logic [FW-1:0] d,
                        input logic [DW-1:0] dst, input logic t, input logic c);
        bit fire, ovf, accept_credit;
        @(negedge clk);
        valid_in   = v;
        data_in    = d;
        dest_in    = dst;
        is_tail_in = t;
        credit_in  = c;
        #1;
        check({where, ".ready"}, 64'(ready_out), 64'(m_outstanding < DEPTH));
        fire          = v && (m_outstanding < DEPTH);
        ovf           = c && (m_outstanding == 0) && !fire;
        accept_credit = c && !ovf;
        @(posedge clk);
        m_outstanding = m_outstanding + (fire ? 1 : 0) - (accept_credit ? 1 : 0);
        if (ovf) m_err_ovf = 1;
        m_send = fire;
        if (fire) begin
            m_data = d;
            m_tail = t;
            if (!m_in_pkt) begin
                m_dest = dst;
                if (!t) begin
                    m_in_pkt = 1;
                    m_lock   = dst;
                end
            end else begin
                m_dest = m_lock;
                if (dst != m_lock) m_err_dest = 1;
                if (t) m_in_pkt = 0;
            end
        end
        #1;
        if (send_out) obs_sends++;
        check_outputs(where);
        $display("cyc %s v=%0b c=%0b fire=%0b send=%0b dest=%0h cnt=%0d", where, v, c,
                 fire, send_out, dest_out, credit_count);
    endtask

    // Asynchronous reset applied between clock edges. It must clear the outputs at once.
    task automatic apply_reset(input string where);
        valid_in  = 0;
        credit_in = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_outputs(where);
        check({where, ".ready"}, 64'(ready_out), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        obs_sends = 0;
        #3;
        apply_reset("rst0");

        // Scenario 1: valid held high and no credits returned. Exactly DEPTH sends.
        for (int i = 0; i < 6; i++) step("drain", 1, FW'(32'hA000 + i), 8'h10, 1, 0);
        check("drain.sends", 64'(obs_sends), 64'(DEPTH));
        check("drain.ready0", 64'(ready_out), 64'd0);

        // Scenario 2: one credit at count 0 allows exactly one more send.
        step("cred1", 1, 32'hB001, 8'h20, 1, 1);
        step("cred1b", 1, 32'hB002, 8'h20, 1, 0);
        step("cred1c", 1, 32'hB003, 8'h20, 1, 0);

        // Scenario 3: count 2, fire and credit in the same cycle.
        step("fill", 0, 32'h0, 8'h0, 0, 1);
        step("fill", 0, 32'h0, 8'h0, 0, 1);
        obs_sends = 0;
        for (int i = 0; i < 5; i++) step("steady", 1, FW'(32'hC000 + i), 8'h30, 1, 1);
        check("steady.sends", 64'(obs_sends), 64'd5);
        check("steady.count", 64'(credit_count), 64'd2);

        // Scenario 4: a 3-flit packet whose dest changes, then a single flit.
        step("fill", 0, 32'h0, 8'h0, 0, 1);
        step("fill", 0, 32'h0, 8'h0, 0, 1);
        step("pkt", 1, 32'hD001, 8'h11, 0, 0);
        step("pkt", 1, 32'hD002, 8'h22, 0, 0);
        step("pkt", 1, 32'hD003, 8'h33, 1, 0);
        check("pkt.dest", 64'(dest_out), 64'h11);
        check("pkt.edest", 64'(err_dest_change), 64'd1);
        step("single", 1, 32'hD004, 8'h44, 1, 0);
        check("single.dest", 64'(dest_out), 64'h44);

        // Scenario 5: overflow at full count.
        for (int i = 0; i < DEPTH; i++) step("refill", 0, 32'h0, 8'h0, 0, 1);
        step("ovf", 0, 32'h0, 8'h0, 0, 1);
        check("ovf.count", 64'(credit_count), 64'(DEPTH));
        step("ovf_hold", 0, 32'h0, 8'h0, 0, 0);
        check("ovf.sticky", 64'(err_credit_overflow), 64'd1);

        // Scenario 6: reset mid-packet with count 1.
        step("mid", 1, 32'hE001, 8'h66, 0, 0);
        step("mid", 1, 32'hE002, 8'h66, 0, 0);
        step("mid", 1, 32'hE003, 8'h66, 0, 0);
        check("mid.count", 64'(credit_count), 64'd1);
        apply_reset("rst_mid");
        step("post", 1, 32'hF001, 8'h55, 0, 0);
        check("post.dest", 64'(dest_out), 64'h55);
        step("post", 1, 32'hF002, 8'h55, 1, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic          v, t, c;
            logic [DW-1:0] dst;
            v   = ($urandom_range(0, 9) < 7);
            t   = ($urandom_range(0, 9) < 3);
            c   = (m_outstanding > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
            dst = (m_in_pkt && $urandom_range(0, 9) != 0) ? m_lock : DW'($urandom);
            step("rand", v, FW'($urandom), dst, t, c);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/noc_credit_sender.md
Name: noc_credit_sender

Overview:
- Transmit end of the flit/credit link protocol (data, dest, is_tail, send forward; credit backward).
- Sits between a router output port or endpoint (valid/ready upstream) and a pipeline link feeding a downstream input buffer of BUFFER_DEPTH flits.
- Tracks downstream buffer credits and issues a registered send only when a credit is available.
- Locks the destination for the duration of a packet and flags protocol errors.

Parameters:
- FLIT_WIDTH, 128, flit payload width.
- DEST_WIDTH, 8, destination field width.
- BUFFER_DEPTH, 8, downstream buffer depth; this is the initial credit count. Legal range is 1 or more.
- CREDIT_WIDTH, $clog2(BUFFER_DEPTH+1), derived width of the credit counter; not to be overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  FLIT_WIDTH  upstream flit payload
- dest_in  in  DEST_WIDTH  upstream destination; sampled on head flits only
- is_tail_in  in  1  upstream flit is the last of its packet
- valid_in  in  1  upstream flit valid
- ready_out  out  1  sender accepts the flit this cycle
- data_out  out  FLIT_WIDTH  link payload
- dest_out  out  DEST_WIDTH  link destination
- is_tail_out  out  1  link tail marker
- send_out  out  1  link flit strobe
- credit_in  in  1  one credit returned from the downstream buffer
- credit_count  out  CREDIT_WIDTH  current credit counter value
- err_credit_overflow  out  1  sticky: a credit was returned while the counter was already at BUFFER_DEPTH
- err_dest_change  out  1  sticky: dest_in differed from the locked dest on an accepted non-head flit

Behaviour:
- Reset is asynchronous on the falling edge of rst_n. All state clears immediately:
  - credit_count = BUFFER_DEPTH
  - send_out, is_tail_out, data_out, dest_out = 0
  - both error flags = 0
  - FSM = IDLE
- Reset mid-packet abandons the packet. No tail is emitted. The downstream side is reset by the same rst_n.
- ready_out = (credit_count != 0). It is driven only from the counter register, with no combinational path from credit_in or valid_in.
- fire = valid_in & ready_out.
- Latency is 1 cycle. On a fire in cycle N, cycle N+1 shows send_out=1 with data_out/is_tail_out = values sampled in N, and dest_out = the effective dest.
- Without a fire, send_out=0 the next cycle. data_out, dest_out and is_tail_out hold their last values; downstream must ignore them when send_out=0.
- Credit counter: next = count - fire + (credit_in & ~overflow). Simultaneous fire and credit_in leaves the count unchanged.
- If credit_count == 0 and credit_in arrives, ready_out rises in the next cycle, not the same cycle.
- Overflow: credit_in=1 with count==BUFFER_DEPTH and no fire in that cycle. The count saturates at BUFFER_DEPTH and err_credit_overflow sets. It clears only on reset.
- Credit_in with a fire at count==BUFFER_DEPTH is legal: the count stays at BUFFER_DEPTH.
- FSM states:
  - IDLE: the next accepted flit is a head flit.
  - IN_PKT: inside a multi-flit packet.
- FSM transitions:
  - IDLE, fire, is_tail_in=1: single-flit packet. dest_out = dest_in. Stay in IDLE.
  - IDLE, fire, is_tail_in=0: lock dest_in into dest_lock. dest_out = dest_in. Go to IN_PKT.
  - IN_PKT, fire: dest_out = dest_lock, whatever dest_in is. If dest_in != dest_lock, set err_dest_change. If is_tail_in=1, go to IDLE; otherwise stay.
  - No fire: state is unchanged.
- Invariants:
  - Sends are never issued with zero credits.
  - Total sends minus returned credits never exceeds BUFFER_DEPTH.

Test Plan (BUFFER_DEPTH=4, FLIT_WIDTH=32, DEST_WIDTH=8):
- Reset, then valid_in held 1 with no credits returned -> exactly 4 send_out pulses on consecutive cycles, ready_out=0 after the 4th fire, credit_count=0.
- From count 0, one credit_in pulse -> ready_out=1 next cycle, one further send, count back to 0.
- Count 2, fire and credit_in in the same cycle for 5 cycles -> count stays 2, 5 back-to-back sends.
- 3-flit packet with dest_in 0x11, 0x22, 0x33 -> dest_out = 0x11 on all three flits, err_dest_change=1, FSM back in IDLE after the tail; next single-flit packet with dest 0x44 -> dest_out=0x44.
- Count 4, credit_in=1 with no fire -> count stays 4, err_credit_overflow=1 and remains set.
- rst_n asserted mid-packet with count=1 -> outputs clear immediately; after release count=4, FSM in IDLE, next flit treated as head with its own dest.
